powerup_pickup_detector: RTL and testbench

- Consumer side of the powerup manager's interface: reads the three powerup slots (position, type, visible) plus the player position and the maze bitmap once per frame.
- Produces the per-slot one-cycle pickedUp pulses and the onWall flag that the manager consumes.
- Multi-cycle scanner: one slot per cycle, then a sequential divide-by-tile-height for the wall lookup. It sits between the player-movement logic and powerup_manager.

---
 rtl/powerup_pickup_detector.sv | 195 +++++++++++++++++++
 tb/tb_powerup_pickup_detector.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/powerup_pickup_detector.sv
// Powerup pickup detector: once per frame snapshots player, powerup slots and
// maze, tests each slot for hitbox overlap (one slot per cycle), divides the
// player centre y by the tile height to find the maze row, then issues
// one-cycle pickedUp pulses together with the onWall flag.
module powerup_pickup_detector #(
  parameter int TILE_WIDTH  = 32,
  parameter int TILE_HEIGHT = 24,
  parameter int MAZE_W      = 20,
  parameter int MAZE_H      = 20,
  parameter int PLAYER_W    = 16,
  parameter int PLAYER_H    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              frame_tick,
  input  logic [9:0]        playerX,
  input  logic [9:0]        playerY,
  input  logic [9:0]        powerupX       [0:2],
  input  logic [9:0]        powerupY       [0:2],
  input  logic [1:0]        powerupType    [0:2],
  input  logic              powerupVisible [0:2],
  input  logic [MAZE_W-1:0] outmaze        [0:MAZE_H-1],
  output logic              pickedUp       [0:2],
  output logic              onWall,
  output logic [7:0]        pickup_count,
  output logic [1:0]        last_type,
  output logic              busy
);

  localparam int unsigned NSLOT    = 3;
  localparam int unsigned TW_SHIFT = $clog2(TILE_WIDTH);
  localparam int unsigned COLW     = $clog2(MAZE_W);
  localparam int unsigned ROWW     = $clog2(MAZE_H);
  localparam logic [10:0] TW11     = 11'(TILE_WIDTH);
  localparam logic [10:0] TH11     = 11'(TILE_HEIGHT);
  localparam logic [10:0] PW11     = 11'(PLAYER_W);
  localparam logic [10:0] PH11     = 11'(PLAYER_H);
  localparam logic [10:0] MW11     = 11'(MAZE_W);
  localparam logic [10:0] MH11     = 11'(MAZE_H);
  localparam logic [4:0]  QMAX     = 5'd31;

  typedef enum logic [2:0] {IDLE, SCAN, DIV, WALL, ISSUE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        idx_q;
  logic [9:0]        px_q, py_q;
  logic [9:0]        ux_q   [0:NSLOT-1];
  logic [9:0]        uy_q   [0:NSLOT-1];
  logic [1:0]        ty_q   [0:NSLOT-1];
  logic [NSLOT-1:0]  vis_q;
  logic [MAZE_W-1:0] maze_q [0:MAZE_H-1];
  logic [10:0]       xc_q, rem_q;
  logic [4:0]        q_q;
  logic [NSLOT-1:0]  armed_q, hit_q, picked_q;
  logic              onwall_q;
  logic [7:0]        cnt_q;
  logic [1:0]        last_q;

  logic              start;
  logic              div_step;
  logic              overlap;
  logic [10:0]       tx;
  logic              wall_bit;
  logic [1:0]        first_ty;
  logic [1:0]        pop;
  logic [8:0]        cnt_sum;

  assign start    = (state_q == IDLE) && frame_tick;
  // Divider stops on the remainder falling below a tile or on the quotient cap.
  assign div_step = (rem_q >= TH11) && (q_q != QMAX);
  assign tx       = xc_q >> TW_SHIFT;
  assign busy     = (state_q != IDLE);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (frame_tick) state_d = SCAN;
      SCAN:    if (idx_q == 2'd2) state_d = DIV;
      DIV:     if (!div_step) state_d = WALL;
      WALL:    state_d = ISSUE;
      ISSUE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Hitbox overlap of the slot currently addressed by the scan index.
  always_comb begin
    logic [10:0] px, py, ux, uy;
    px      = {1'b0, px_q};
    py      = {1'b0, py_q};
    ux      = {1'b0, ux_q[idx_q]};
    uy      = {1'b0, uy_q[idx_q]};
    overlap = (px < ux + TW11) && (ux < px + PW11) &&
              (py < uy + TH11) && (uy < py + PH11);
  end

  // Maze lookup at the player centre; anything outside the maze is floor.
  always_comb begin
    wall_bit = 1'b0;
    if ((tx < MW11) && ({6'd0, q_q} < MH11))
      wall_bit = maze_q[q_q[ROWW-1:0]][tx[COLW-1:0]];
  end

  // Pickup bookkeeping: hit popcount, saturating sum, lowest-index hit type.
  always_comb begin
    pop      = {1'b0, hit_q[0]} + {1'b0, hit_q[1]} + {1'b0, hit_q[2]};
    cnt_sum  = {1'b0, cnt_q} + {7'd0, pop};
    first_ty = ty_q[2];
    if (hit_q[1]) first_ty = ty_q[1];
    if (hit_q[0]) first_ty = ty_q[0];
  end

  // Frame snapshot of all live inputs; only meaningful while a scan runs.
  always_ff @(posedge clk) begin
    if (start) begin
      px_q <= playerX;
      py_q <= playerY;
      for (int unsigned i = 0; i < NSLOT; i++) begin
        ux_q[i]  <= powerupX[i];
        uy_q[i]  <= powerupY[i];
        ty_q[i]  <= powerupType[i];
        vis_q[i] <= powerupVisible[i];
      end
      for (int unsigned r = 0; r < MAZE_H; r++) maze_q[r] <= outmaze[r];
    end
  end

  // Scan datapath and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q    <= '0;
      xc_q     <= '0;
      rem_q    <= '0;
      q_q      <= '0;
      armed_q  <= '1;
      hit_q    <= '0;
      picked_q <= '0;
      onwall_q <= 1'b0;
      cnt_q    <= '0;
      last_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (frame_tick) begin
            idx_q <= '0;
            xc_q  <= {1'b0, playerX} + 11'(PLAYER_W / 2);
            rem_q <= {1'b0, playerY} + 11'(PLAYER_H / 2);
            q_q   <= '0;
          end
        end
        SCAN: begin
          // A slot re-arms only once a scan has seen it invisible.
          if (!vis_q[idx_q]) armed_q[idx_q] <= 1'b1;
          hit_q[idx_q] <= vis_q[idx_q] & armed_q[idx_q] & overlap;
          if (idx_q != 2'd2) idx_q <= idx_q + 2'd1;
        end
        DIV: begin
          if (div_step) begin
            rem_q <= rem_q - TH11;
            q_q   <= q_q + 5'd1;
          end
        end
        WALL: begin
          picked_q <= hit_q;
          armed_q  <= armed_q & ~hit_q;
          onwall_q <= wall_bit;
          cnt_q    <= cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
          if (|hit_q) last_q <= first_ty;
        end
        ISSUE: begin
          picked_q <= '0;
          hit_q    <= '0;
        end
        default: ;
      endcase
    end
  end

  // Output mapping.
  always_comb begin
    for (int unsigned i = 0; i < NSLOT; i++) pickedUp[i] = picked_q[i];
  end

  assign onWall       = onwall_q;
  assign pickup_count = cnt_q;
  assign last_type    = last_q;

endmodule

// File: tb/tb_powerup_pickup_detector.sv
// Directed, table-driven bench for powerup_pickup_detector.
module tb_powerup_pickup_detector;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        frame_tick;
  logic [9:0]  playerX, playerY;
  logic [9:0]  powerupX       [0:2];
  logic [9:0]  powerupY       [0:2];
  logic [1:0]  powerupType    [0:2];
  logic        powerupVisible [0:2];
  logic [19:0] outmaze        [0:19];
  logic        pickedUp       [0:2];
  logic        onWall;
  logic [7:0]  pickup_count;
  logic [1:0]  last_type;
  logic        busy;

  logic [19:0] maze_ref [0:19];

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  typedef struct {
    logic [9:0]       px, py;
    logic [2:0][9:0]  ux, uy;
    logic [2:0][1:0]  ty;
    logic [2:0]       vis;
    logic [2:0]       exp_pu;
    logic             exp_wall;
    logic [7:0]       exp_cnt;
    logic [1:0]       exp_last;
    int unsigned      q;
  } vec_t;

  vec_t vecs [13];

  powerup_pickup_detector #(
    .TILE_WIDTH (32),
    .TILE_HEIGHT(24),
    .MAZE_W     (20),
    .MAZE_H     (20),
    .PLAYER_W   (16),
    .PLAYER_H   (16)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .frame_tick    (frame_tick),
    .playerX       (playerX),
    .playerY       (playerY),
    .powerupX      (powerupX),
    .powerupY      (powerupY),
    .powerupType   (powerupType),
    .powerupVisible(powerupVisible),
    .outmaze       (outmaze),
    .pickedUp      (pickedUp),
    .onWall        (onWall),
    .pickup_count  (pickup_count),
    .last_type     (last_type),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] pu_now();
    return {pickedUp[2], pickedUp[1], pickedUp[0]};
  endfunction

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int px, int py,
                              int ux0, int uy0, int t0,
                              int ux1, int uy1, int t1,
                              int ux2, int uy2, int t2,
                              logic [2:0] vis, logic [2:0] pu, logic wall,
                              int cnt, int last, int q);
    vec_t r;
    r.px = 10'(px);   r.py = 10'(py);
    r.ux[0] = 10'(ux0); r.uy[0] = 10'(uy0); r.ty[0] = 2'(t0);
    r.ux[1] = 10'(ux1); r.uy[1] = 10'(uy1); r.ty[1] = 2'(t1);
    r.ux[2] = 10'(ux2); r.uy[2] = 10'(uy2); r.ty[2] = 2'(t2);
    r.vis = vis; r.exp_pu = pu; r.exp_wall = wall;
    r.exp_cnt = 8'(cnt); r.exp_last = 2'(last); r.q = q;
    return r;
  endfunction

  task automatic apply_inputs(input vec_t v);
    playerX = v.px;
    playerY = v.py;
    for (int unsigned i = 0; i < 3; i++) begin
      powerupX[i]       = v.ux[i];
      powerupY[i]       = v.uy[i];
      powerupType[i]    = v.ty[i];
      powerupVisible[i] = v.vis[i];
    end
    for (int unsigned r = 0; r < 20; r++) outmaze[r] = maze_ref[r];
  endtask

  // Live inputs that would change every result if they leaked past the snapshot.
  task automatic scramble_inputs();
    playerX = 10'd300;
    playerY = 10'd300;
    for (int unsigned i = 0; i < 3; i++) begin
      powerupX[i]       = 10'd300;
      powerupY[i]       = 10'd300;
      powerupType[i]    = 2'd3;
      powerupVisible[i] = 1'b1;
    end
    for (int unsigned r = 0; r < 20; r++) outmaze[r] = '1;
  endtask

  // One full frame; called at #1 after a rising edge with the DUT idle.
  task automatic run_frame(input vec_t v, input string tag, input bit retick);
    int unsigned last;
    last = v.q + 6;
    apply_inputs(v);
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    scramble_inputs();
    for (int unsigned k = 1; k <= last; k++) begin
      if (retick && k == 2) frame_tick = 1'b1;
      if (retick && k == 3) frame_tick = 1'b0;
      @(posedge clk); #1;
      if (k == 1) check({tag, " busy_start"}, busy, 1);
      if (k < v.q + 5) check({tag, " early_pulse"}, pu_now(), 0);
      if (k == v.q + 5) begin
        check({tag, " pickedUp"}, pu_now(), v.exp_pu);
        check({tag, " onWall"}, onWall, v.exp_wall);
        check({tag, " count"}, pickup_count, v.exp_cnt);
        check({tag, " last_type"}, last_type, v.exp_last);
        check({tag, " busy_issue"}, busy, 1);
      end
      if (k == last) begin
        check({tag, " pulse_end"}, pu_now(), 0);
        check({tag, " busy_end"}, busy, 0);
      end
    end
    if (retick) begin
      for (int unsigned k = 0; k < 4; k++) begin
        @(posedge clk); #1;
        check({tag, " no_rescan_busy"}, busy, 0);
        check({tag, " no_rescan_pulse"}, pu_now(), 0);
      end
      check({tag, " no_rescan_count"}, pickup_count, v.exp_cnt);
    end
  endtask

  initial begin
    vec_t v;
    logic seen;

    for (int unsigned r = 0; r < 20; r++) maze_ref[r] = '0;
    maze_ref[0][0]   = 1'b1;
    maze_ref[1][1]   = 1'b1;
    maze_ref[4][3]   = 1'b1;
    maze_ref[19][19] = 1'b1;

    //                px   py  ux0 uy0 t0  ux1 uy1 t1  ux2 uy2 t2  vis     pu      wall cnt last q
    vecs[0]  = mk(  0,   0,   0,  0, 1, 900,900, 0, 900,900, 0, 3'b001, 3'b001, 1,   1,  1,  0);
    vecs[1]  = mk(100, 100, 600,400, 0,   0,  0, 0, 900,  0, 0, 3'b100, 3'b000, 1,   1,  1,  4);
    vecs[2]  = mk(200,  48, 200, 48, 0, 900,900, 0, 900,900, 0, 3'b001, 3'b001, 0,   2,  0,  2);
    vecs[3]  = mk(200,  48, 200, 48, 0, 900,900, 0, 900,900, 0, 3'b001, 3'b000, 0,   2,  0,  2);
    vecs[4]  = mk(200,  48, 200, 48, 0, 900,900, 0, 900,900, 0, 3'b000, 3'b000, 0,   2,  0,  2);
    vecs[5]  = mk(200,  48, 200, 48, 0, 900,900, 0, 900,900, 0, 3'b001, 3'b001, 0,   3,  0,  2);
    vecs[6]  = mk( 40,  24, 900,900, 0, 900,900, 0, 900,900, 0, 3'b000, 3'b000, 1,   3,  0,  1);
    vecs[7]  = mk( 40,  24,  30, 20, 2, 300,300, 1,  50, 30, 0, 3'b111, 3'b101, 1,   5,  2,  1);
    vecs[8]  = mk( 40,  24, 900,900, 0, 900,900, 0, 900,900, 0, 3'b000, 3'b000, 1,   5,  2,  1);
    vecs[9]  = mk( 40,  24,  56, 24, 1,   8, 24, 2,  40,  0, 0, 3'b111, 3'b000, 1,   5,  2,  1);
    vecs[10] = mk( 40,  24,  55, 24, 1,   9, 24, 2,  40,  1, 0, 3'b111, 3'b111, 1,   8,  1,  1);
    vecs[11] = mk(700, 900, 900,900, 0, 900,900, 0, 900,900, 0, 3'b000, 3'b000, 0,   8,  1, 31);
    vecs[12] = mk(620, 450, 900,900, 0, 900,900, 0, 900,900, 0, 3'b000, 3'b000, 1,   8,  1, 19);

    reset_n    = 1'b0;
    frame_tick = 1'b0;
    apply_inputs(vecs[0]);
    repeat (3) @(posedge clk);
    #1;
    check("reset pickedUp", pu_now(), 0);
    check("reset onWall", onWall, 0);
    check("reset count", pickup_count, 0);
    check("reset last_type", last_type, 0);
    check("reset busy", busy, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int unsigned i = 0; i < 13; i++)
      run_frame(vecs[i], $sformatf("vec%0d", i), 1'b0);

    // Second frame_tick during SCAN must not start another scan.
    v = mk(0, 0, 0, 0, 1, 900, 900, 0, 900, 900, 0, 3'b001, 3'b001, 1, 9, 1, 0);
    run_frame(v, "retick", 1'b1);

    // Reset while the divider is running aborts the pending pickup.
    v = mk(100, 100, 900, 900, 0, 100, 100, 2, 900, 900, 0, 3'b010, 3'b000, 1, 0, 0, 4);
    apply_inputs(v);
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("midscan busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check("abort pickedUp", pu_now(), 0);
    check("abort onWall", onWall, 0);
    check("abort count", pickup_count, 0);
    check("abort last_type", last_type, 0);
    check("abort busy", busy, 0);
    @(posedge clk);
    @(posedge clk); #1;
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      seen = seen | (|pu_now()) | busy;
    end
    check("abort no_pulse", seen, 0);
    check("abort count_after", pickup_count, 0);

    // Drive the counter to 254 with single pickups, then saturate.
    for (int unsigned i = 0; i < 254; i++) begin
      v = mk(0, 0, 0, 0, 1, 900, 900, 0, 900, 900, 0, 3'b001, 3'b001, 1, i + 1, 1, 0);
      run_frame(v, $sformatf("single%0d", i), 1'b0);
      v = mk(0, 0, 0, 0, 1, 900, 900, 0, 900, 900, 0, 3'b000, 3'b000, 1, i + 1, 1, 0);
      run_frame(v, $sformatf("rearm%0d", i), 1'b0);
    end
    v = mk(0, 0, 0, 0, 2, 0, 0, 1, 0, 0, 0, 3'b111, 3'b111, 1, 255, 2, 0);
    run_frame(v, "sat_triple", 1'b0);
    v = mk(0, 0, 0, 0, 2, 0, 0, 1, 0, 0, 0, 3'b000, 3'b000, 1, 255, 2, 0);
    run_frame(v, "sat_rearm", 1'b0);
    v = mk(0, 0, 0, 0, 2, 0, 0, 1, 0, 0, 0, 3'b111, 3'b111, 1, 255, 2, 0);
    run_frame(v, "sat_hold", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
